// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - core_config (division width) and core_types (op codes, FSM states) packages
package core_config;
   localparam int DIV_W = 32;
   localparam int CNT_W = $clog2(DIV_W);
endpackage

package core_types;
   import core_config::*;

   typedef enum logic [2:0] {
      DIV_OP_DIV  = 3'd4,
      DIV_OP_DIVU = 3'd5,
      DIV_OP_MOD  = 3'd6,
      DIV_OP_MODU = 3'd7
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } div_state_e;

   // Magnitude of an operand; unsigned operands pass through untouched.
   function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v, input logic is_signed);
      return (is_signed && v[DIV_W-1]) ? (DIV_W'(0) - v) : v;
   endfunction
endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response bundle between a requester and div_unit
interface div_unit_if;
   import core_config::*;

   logic             clear_pipeline;
   logic [2:0]       div_para;
   logic             div_initial;
   logic [DIV_W-1:0] div_rs0;
   logic [DIV_W-1:0] div_rs1;
   logic             div_ready;
   logic             div_finished;
   logic [DIV_W-1:0] div_data;
   logic             div_ack;

   modport master (
      output clear_pipeline, div_para, div_initial, div_rs0, div_rs1, div_ack,
      input  div_ready, div_finished, div_data
   );

   modport slave (
      input  clear_pipeline, div_para, div_initial, div_rs0, div_rs1, div_ack,
      output div_ready, div_finished, div_data
   );
endinterface

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one combinational radix-2 restoring division iteration
module div_step
   import core_config::*;
(
   input  logic [DIV_W:0]   partial,
   input  logic [DIV_W-1:0] divisor,
   output logic [DIV_W-1:0] next_rem,
   output logic             q_bit
);
   logic [DIV_W:0] diff;

   // Trial subtract; keep the difference only when it did not borrow.
   always_comb begin
      diff     = partial - {1'b0, divisor};
      q_bit    = ~diff[DIV_W];
      next_rem = q_bit ? diff[DIV_W-1:0] : partial[DIV_W-1:0];
   end
endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit divider (div/divu/mod/modu); optional DIV_EARLY_OUT_EN shortcut
module div_unit
   import core_config::*;
   import core_types::*;
(
   input logic       clk,
   input logic       rst,
   div_unit_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       op_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic             zero_div_q;
   logic [DIV_W-1:0] rem_q;
   logic [DIV_W-1:0] work_q;
   logic [DIV_W-1:0] divisor_q;
   logic [DIV_W-1:0] data_q;
   logic             ready_q;
   logic             finished_q;

   logic             start_ok;
   logic             in_signed;
   logic [DIV_W-1:0] a_abs;
   logic [DIV_W-1:0] b_abs;
   logic [DIV_W-1:0] next_rem;
   logic             q_bit;
   logic             early_sel;
   logic [DIV_W-1:0] quo_raw;
   logic [DIV_W-1:0] rem_raw;
   logic [DIV_W-1:0] quo_fix;
   logic [DIV_W-1:0] rem_fix;
   logic [DIV_W-1:0] result;

`ifdef DIV_EARLY_OUT_EN
   logic early_q;
   logic early_in;
`endif

   assign bus.div_ready    = ready_q;
   assign bus.div_finished = finished_q;
   assign bus.div_data     = data_q;

   // work_q shifts dividend bits out of the top while quotient bits fill the bottom.
   div_step u_step (
      .partial  ({rem_q, work_q[DIV_W-1]}),
      .divisor  (divisor_q),
      .next_rem (next_rem),
      .q_bit    (q_bit)
   );

   // Start qualification and operand magnitudes from the request bus.
   always_comb begin
      start_ok  = (state_q == ST_IDLE) && bus.div_initial && bus.div_para[2] && !bus.clear_pipeline;
      in_signed = ~bus.div_para[0];
      a_abs     = abs_val(bus.div_rs0, in_signed);
      b_abs     = abs_val(bus.div_rs1, in_signed);
   end

`ifdef DIV_EARLY_OUT_EN
   // Dividend magnitude below divisor (zero included) means the answer is known up front.
   always_comb begin
      early_in  = (b_abs != '0) && (a_abs < b_abs);
      early_sel = early_q;
   end
`else
   // No shortcut: every operation runs the full iteration count.
   always_comb begin
      early_sel = 1'b0;
   end
`endif

   // Final sign fix-up, divide-by-zero override and op selection.
   always_comb begin
      quo_raw = early_sel ? '0 : {work_q[DIV_W-2:0], q_bit};
      rem_raw = early_sel ? work_q : next_rem;
      quo_fix = zero_div_q ? '1 : (neg_quo_q ? ('0 - quo_raw) : quo_raw);
      rem_fix = neg_rem_q ? ('0 - rem_raw) : rem_raw;
      case (op_q)
         DIV_OP_DIV, DIV_OP_DIVU: result = quo_fix;
         DIV_OP_MOD, DIV_OP_MODU: result = rem_fix;
         default:                 result = quo_fix;
      endcase
   end

   // Control FSM, iteration datapath and registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_q       <= 3'd0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         zero_div_q <= 1'b0;
         rem_q      <= '0;
         work_q     <= '0;
         divisor_q  <= '0;
         data_q     <= '0;
         ready_q    <= 1'b1;
         finished_q <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
         early_q    <= 1'b0;
`endif
      end else if (bus.clear_pipeline) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ready_q    <= 1'b1;
         finished_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  state_q    <= ST_CALC;
                  ready_q    <= 1'b0;
                  cnt_q      <= '0;
                  op_q       <= bus.div_para;
                  neg_quo_q  <= in_signed & (bus.div_rs0[DIV_W-1] ^ bus.div_rs1[DIV_W-1]);
                  neg_rem_q  <= in_signed & bus.div_rs0[DIV_W-1];
                  zero_div_q <= (bus.div_rs1 == '0);
                  rem_q      <= '0;
                  work_q     <= a_abs;
                  divisor_q  <= b_abs;
`ifdef DIV_EARLY_OUT_EN
                  early_q    <= early_in;
`endif
               end
            end
            ST_CALC: begin
               if (early_sel || (cnt_q == CNT_LAST)) begin
                  state_q    <= ST_DONE;
                  finished_q <= 1'b1;
                  data_q     <= result;
                  cnt_q      <= '0;
               end else begin
                  rem_q  <= next_rem;
                  work_q <= {work_q[DIV_W-2:0], q_bit};
                  cnt_q  <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (bus.div_ack) begin
                  state_q    <= ST_IDLE;
                  ready_q    <= 1'b1;
                  finished_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               ready_q    <= 1'b1;
               finished_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;
   logic clk;
   logic rst;
   int   edge_cnt;
   int   n_pass;
   int   n_total;
   logic prev_fin;
   logic [31:0] last_exp;

   typedef struct {
      logic [31:0] data;
      int          edge_n;
   } exp_t;

   exp_t exp_q[$];

   div_unit_if bus();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every rising div_finished must match the oldest expected result and latency.
   always @(negedge clk) begin
      if (rst && bus.div_finished && !prev_fin) begin
         if (exp_q.size() == 0) begin
            check("unexpected_finish", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result_data", bus.div_data, e.data);
            check("finish_edge", 32'(edge_cnt), 32'(e.edge_n));
         end
      end
      prev_fin <= bus.div_finished;
   end

   task automatic run_op(input logic [2:0] para, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit early, input int hold,
                         input bit stray, input bit start_on_ack);
      bit got;
      @(negedge clk);
      bus.div_para    = para;
      bus.div_rs0     = a;
      bus.div_rs1     = b;
      bus.div_initial = 1'b1;
      exp_q.push_back('{data: exp, edge_n: edge_cnt + (early ? 2 : 33)});
      @(negedge clk);
      bus.div_initial = 1'b0;
      bus.div_rs0     = 32'h1234_5678;
      bus.div_rs1     = 32'h0000_0000;
      if (stray) begin
         repeat (4) @(negedge clk);
         bus.div_ack = 1'b1;
         @(negedge clk);
         bus.div_ack = 1'b0;
         check("stray_ack_busy", bus.div_ready, 1'b0);
      end
      got = 1'b0;
      if (bus.div_finished) got = 1'b1;
      for (int i = 0; i < 80 && !got; i++) begin
         @(negedge clk);
         if (bus.div_finished) got = 1'b1;
      end
      if (!got) begin
         check("finish_timeout", 32'd0, 32'd1);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_finished", bus.div_finished, 1'b1);
         check("hold_data", bus.div_data, exp);
      end
      bus.div_ack = 1'b1;
      if (start_on_ack) begin
         bus.div_para    = 3'd5;
         bus.div_rs0     = 32'd9;
         bus.div_rs1     = 32'd3;
         bus.div_initial = 1'b1;
      end
      @(negedge clk);
      bus.div_ack     = 1'b0;
      bus.div_initial = 1'b0;
      check("ack_ready", bus.div_ready, 1'b1);
      check("ack_finished_low", bus.div_finished, 1'b0);
      if (start_on_ack) begin
         @(negedge clk);
         check("start_dropped", bus.div_ready, 1'b1);
      end
      last_exp = exp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit eo;
      edge_cnt = 0;
      n_pass   = 0;
      n_total  = 0;
      prev_fin = 1'b0;
      last_exp = 32'd0;
      rst                = 1'b0;
      bus.clear_pipeline = 1'b0;
      bus.div_para       = 3'd0;
      bus.div_initial    = 1'b0;
      bus.div_rs0        = 32'd0;
      bus.div_rs1        = 32'd0;
      bus.div_ack        = 1'b0;
      #12;
      check("reset_ready", bus.div_ready, 1'b1);
      check("reset_finished", bus.div_finished, 1'b0);
      check("reset_data", bus.div_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd7, 32'd5, 32'd0, 32'd5, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0);
      run_op(3'd4, 32'd100, 32'd7, 32'd14, 1'b0, 10, 1'b1, 1'b0);
      run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 0, 1'b0, 1'b1);

`ifdef DIV_EARLY_OUT_EN
      eo = 1'b1;
`else
      eo = 1'b0;
`endif
      run_op(3'd5, 32'd3, 32'd10, 32'd0, eo, 0, 1'b0, 1'b0);
      run_op(3'd7, 32'd3, 32'd10, 32'd3, eo, 0, 1'b0, 1'b0);

      // Illegal op code leaves the unit idle.
      @(negedge clk);
      bus.div_para    = 3'd1;
      bus.div_rs0     = 32'd8;
      bus.div_rs1     = 32'd2;
      bus.div_initial = 1'b1;
      @(negedge clk);
      bus.div_initial = 1'b0;
      check("illegal_op_idle", bus.div_ready, 1'b1);

      // Abort mid-calculation: back to idle, no result, old data kept.
      @(negedge clk);
      bus.div_para    = 3'd5;
      bus.div_rs0     = 32'd100;
      bus.div_rs1     = 32'd7;
      bus.div_initial = 1'b1;
      @(negedge clk);
      bus.div_initial = 1'b0;
      repeat (10) @(negedge clk);
      check("calc_busy", bus.div_ready, 1'b0);
      bus.clear_pipeline = 1'b1;
      @(negedge clk);
      bus.clear_pipeline = 1'b0;
      check("clear_idle", bus.div_ready, 1'b1);
      check("clear_data_kept", bus.div_data, last_exp);
      repeat (40) @(negedge clk);
      check("clear_no_finish", bus.div_finished, 1'b0);

      // Asynchronous reset mid-calculation.
      @(negedge clk);
      bus.div_para    = 3'd4;
      bus.div_rs0     = 32'd100;
      bus.div_rs1     = 32'd7;
      bus.div_initial = 1'b1;
      @(negedge clk);
      bus.div_initial = 1'b0;
      repeat (15) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("async_rst_ready", bus.div_ready, 1'b1);
      check("async_rst_finished", bus.div_finished, 1'b0);
      check("async_rst_data", bus.div_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op(3'd5, 32'd1000, 32'd10, 32'd100, 1'b0, 0, 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
